vote_tally: RTL and testbench
=============================

VOTE_TALLY -- requirements
Module: vote_tally

Interface
REQ-001 SHALL have parameter NUM_CAND, default 4: number of candidates, 2..8.
REQ-002 SHALL have parameter CNT_W, default 8: width of each per-candidate vote counter.
REQ-003 SHALL have parameter DBNC_CYC, default 4: number of consecutive stable samples the debounce filter requires.
REQ-004 SHALL have port CLK, input, 1 bit: the single clock, driven by ClockGen; all state changes on the rising edge.
REQ-005 SHALL have port RST, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port voter_en, input, 1 bit: level signal from the poll officer authorising one voter.
REQ-007 SHALL have port cand_btn, input, NUM_CAND bits: candidate select buttons, bit i selects candidate i.
REQ-008 SHALL have port cast, input, 1 bit: confirm button.
REQ-009 SHALL have port close_poll, input, 1 bit: request to end voting.
REQ-010 SHALL have port busy, output, 1 bit: high in every state except IDLE and CLOSED.
REQ-011 SHALL have port vote_ack, output, 1 bit: one-cycle pulse when a vote is counted.
REQ-012 SHALL have port err, output, 1 bit: one-cycle pulse when cast is invalid.
REQ-013 SHALL have port tally, output, NUM_CAND*CNT_W bits: counter i occupies bits [i*CNT_W +: CNT_W].
REQ-014 SHALL have port winner, output, 3 bits: index of the leading candidate.
REQ-015 SHALL have port poll_closed, output, 1 bit: high while in CLOSED.

Function
REQ-016 FSM SHALL have exactly five states: IDLE, SELECT, COMMIT, WAIT_REL, CLOSED.
REQ-017 IDLE SHALL go to SELECT at the edge where voter_en=1 and close_poll=0.
REQ-018 In SELECT, cast=1 with exactly one filtered button high SHALL latch that index and go to COMMIT.
REQ-019 In SELECT, cast=1 with zero or more than one button high SHALL pulse err for one cycle and remain in SELECT; the tally SHALL be unchanged.
REQ-020 COMMIT SHALL last one cycle: increment the latched counter, pulse vote_ack in the same cycle the new tally is visible, then go to WAIT_REL.
REQ-021 Latency SHALL be fixed: cast sampled at edge N leads to vote_ack high and the updated tally visible in the cycle after edge N+1.
REQ-022 Counters SHALL saturate at 2^CNT_W-1; an increment at saturation still pulses vote_ack and leaves the counter unchanged.
REQ-023 WAIT_REL SHALL go to IDLE only when voter_en=0, so one authorisation yields at most one vote.
REQ-024 close_poll=1 SHALL force CLOSED from IDLE, SELECT (vote discarded, no ack) or WAIT_REL.
REQ-025 Exception to REQ-024: in SELECT, a valid cast with close_poll in the same cycle SHALL go to COMMIT, and the vote SHALL be counted.
REQ-026 close_poll seen during COMMIT SHALL be latched, and COMMIT SHALL then go to CLOSED instead of WAIT_REL.
REQ-027 CLOSED SHALL be terminal until RST; all inputs are ignored and the tally is frozen.
REQ-028 winner SHALL be the combinational index of the maximum counter; ties resolve to the lowest index; all zero gives 0.

Reset
REQ-029 RST=1 at an edge SHALL, from any state including mid-COMMIT, go to IDLE, clear all counters, clear the close latch and the debounce state, and drive busy=0, vote_ack=0, err=0, poll_closed=0, winner=0.
REQ-030 RST SHALL take priority over every other input.

Configuration
REQ-031 With VOTE_DEBOUNCE_EN defined, each bit of cand_btn and cast SHALL pass a filter: the output changes only after DBNC_CYC consecutive equal samples, adding DBNC_CYC cycles of latency before REQ-021 starts.
REQ-032 Without VOTE_DEBOUNCE_EN, the inputs SHALL be registered by a single flop; one cycle of latency before REQ-021 starts.

Verification
REQ-033 Scenario, normal vote: voter_en=1, cand_btn=0010, cast pulse -> vote_ack once, tally[1]=1, winner=1.
REQ-034 Scenario, invalid cast: cand_btn=0110 with cast -> err one cycle, all counters 0, state SELECT.
REQ-035 Scenario, saturation: CNT_W=2, four votes for candidate 3 -> tally[3]=3 and four acks.
REQ-036 Scenario, one vote per authorisation: voter_en held high, cast twice -> only the first is counted; the second is ignored in WAIT_REL.
REQ-037 Scenario, close: close_poll with a valid cast in SELECT -> vote counted, poll_closed=1, later voter_en ignored.
REQ-038 Scenario, reset: RST asserted during COMMIT -> the next cycle shows tally all zero, IDLE, no vote_ack; checked both with and without VOTE_DEBOUNCE_EN.

Source files
------------

// File: rtl/vote_tally.sv
// vote_tally: single-booth voting controller with saturating per-candidate tallies and a leader index.
// Define VOTE_DEBOUNCE_EN to pass cand_btn/cast through a DBNC_CYC-sample debounce filter instead of one flop.
module vote_tally #(
  parameter int NUM_CAND = 4,
  parameter int CNT_W    = 8,
  parameter int DBNC_CYC = 4
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      voter_en,
  input  logic [NUM_CAND-1:0]       cand_btn,
  input  logic                      cast,
  input  logic                      close_poll,
  output logic                      busy,
  output logic                      vote_ack,
  output logic                      err,
  output logic [NUM_CAND*CNT_W-1:0] tally,
  output logic [2:0]                winner,
  output logic                      poll_closed
);

  if (NUM_CAND < 2 || NUM_CAND > 8 || CNT_W < 1 || DBNC_CYC < 1) begin : g_param_check
    $error("vote_tally: parameter out of range");
  end

  localparam int IN_W = NUM_CAND + 1;

  logic [IN_W-1:0] raw_in;
  logic [IN_W-1:0] filt;

  assign raw_in = {cast, cand_btn};

`ifdef VOTE_DEBOUNCE_EN
  localparam int DC_W = (DBNC_CYC < 2) ? 1 : $clog2(DBNC_CYC);

  logic [DC_W-1:0] stab_cnt [IN_W];

  // A bit's filtered value follows the raw input only after DBNC_CYC consecutive differing samples.
  always_ff @(posedge CLK) begin
    if (RST) begin
      filt <= '0;
      for (int unsigned i = 0; i < IN_W; i++) stab_cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < IN_W; i++) begin
        if (raw_in[i] == filt[i]) begin
          stab_cnt[i] <= '0;
        end else if (stab_cnt[i] == DC_W'(DBNC_CYC - 1)) begin
          filt[i]     <= raw_in[i];
          stab_cnt[i] <= '0;
        end else begin
          stab_cnt[i] <= stab_cnt[i] + DC_W'(1);
        end
      end
    end
  end
`else
  always_ff @(posedge CLK) begin
    if (RST) filt <= '0;
    else     filt <= raw_in;
  end
`endif

  logic                cast_f;
  logic                cast_prev;
  logic                cast_rise;
  logic [NUM_CAND-1:0] btn_f;

  assign cast_f = filt[IN_W-1];
  assign btn_f  = filt[NUM_CAND-1:0];

  // One press of cast is one request, however long it is held.
  always_ff @(posedge CLK) begin
    if (RST) cast_prev <= 1'b0;
    else     cast_prev <= cast_f;
  end

  assign cast_rise = cast_f & ~cast_prev;

  logic [3:0] btn_cnt;
  logic [2:0] btn_idx;
  logic       btn_one;

  always_comb begin
    btn_cnt = '0;
    btn_idx = '0;
    for (int unsigned i = 0; i < NUM_CAND; i++) begin
      if (btn_f[i]) begin
        btn_cnt = btn_cnt + 4'd1;
        btn_idx = 3'(i);
      end
    end
  end

  assign btn_one = (btn_cnt == 4'd1);

  logic [CNT_W-1:0] cnt [NUM_CAND];

  for (genvar g = 0; g < NUM_CAND; g++) begin : g_tally
    assign tally[g*CNT_W +: CNT_W] = cnt[g];
  end

  // Strict comparison keeps the lowest index on ties.
  logic [CNT_W-1:0] best;

  always_comb begin
    winner = '0;
    best   = cnt[0];
    for (int unsigned i = 1; i < NUM_CAND; i++) begin
      if (cnt[i] > best) begin
        best   = cnt[i];
        winner = 3'(i);
      end
    end
  end

  typedef enum logic [2:0] {IDLE, SELECT, COMMIT, WAIT_REL, CLOSED} state_t;

  state_t     state;
  logic [2:0] sel_idx;
  logic       close_lat;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= IDLE;
      sel_idx     <= '0;
      close_lat   <= 1'b0;
      busy        <= 1'b0;
      vote_ack    <= 1'b0;
      err         <= 1'b0;
      poll_closed <= 1'b0;
      for (int unsigned i = 0; i < NUM_CAND; i++) cnt[i] <= '0;
    end else begin
      vote_ack <= 1'b0;
      err      <= 1'b0;
      unique case (state)
        IDLE: begin
          if (close_poll) begin
            state       <= CLOSED;
            poll_closed <= 1'b1;
          end else if (voter_en) begin
            state <= SELECT;
            busy  <= 1'b1;
          end
        end
        SELECT: begin
          // A valid cast wins over a simultaneous close; the close is carried through COMMIT.
          if (cast_rise && btn_one) begin
            state     <= COMMIT;
            sel_idx   <= btn_idx;
            close_lat <= close_poll;
          end else if (close_poll) begin
            state       <= CLOSED;
            busy        <= 1'b0;
            poll_closed <= 1'b1;
          end else if (cast_rise) begin
            err <= 1'b1;
          end
        end
        COMMIT: begin
          for (int unsigned i = 0; i < NUM_CAND; i++) begin
            if (sel_idx == 3'(i) && cnt[i] != '1) cnt[i] <= cnt[i] + CNT_W'(1);
          end
          vote_ack <= 1'b1;
          if (close_lat || close_poll) begin
            state       <= CLOSED;
            busy        <= 1'b0;
            poll_closed <= 1'b1;
          end else begin
            state <= WAIT_REL;
          end
          close_lat <= 1'b0;
        end
        WAIT_REL: begin
          if (close_poll) begin
            state       <= CLOSED;
            busy        <= 1'b0;
            poll_closed <= 1'b1;
          end else if (!voter_en) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        CLOSED: begin
          state <= CLOSED;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vote_tally.sv
// Bench for vote_tally: a default-width and a 2-bit-counter instance driven in lockstep,
// table-driven vote vectors plus hand sequences, with an ack scoreboard.
`timescale 1ns/1ps
module tb_vote_tally;

  localparam int NC  = 4;
  localparam int CW  = 8;
  localparam int CWS = 2;
  localparam int DB  = 4;
`ifdef VOTE_DEBOUNCE_EN
  localparam int L = DB;
`else
  localparam int L = 1;
`endif

  logic          CLK = 1'b0;
  logic          RST;
  logic          voter_en;
  logic [NC-1:0] cand_btn;
  logic          cast;
  logic          close_poll;

  logic             busy, vote_ack, err, poll_closed;
  logic [NC*CW-1:0] tally;
  logic [2:0]       winner;

  logic              busy_sat, vote_ack_sat, err_sat, poll_closed_sat;
  logic [NC*CWS-1:0] tally_sat;
  logic [2:0]        winner_sat;

  vote_tally #(.NUM_CAND(NC), .CNT_W(CW), .DBNC_CYC(DB)) dut (
    .CLK(CLK), .RST(RST), .voter_en(voter_en), .cand_btn(cand_btn), .cast(cast),
    .close_poll(close_poll), .busy(busy), .vote_ack(vote_ack), .err(err),
    .tally(tally), .winner(winner), .poll_closed(poll_closed)
  );

  vote_tally #(.NUM_CAND(NC), .CNT_W(CWS), .DBNC_CYC(DB)) dut_sat (
    .CLK(CLK), .RST(RST), .voter_en(voter_en), .cand_btn(cand_btn), .cast(cast),
    .close_poll(close_poll), .busy(busy_sat), .vote_ack(vote_ack_sat), .err(err_sat),
    .tally(tally_sat), .winner(winner_sat), .poll_closed(poll_closed_sat)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int total  = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Reference model of both counter banks.
  int em [NC];
  int es [NC];

  typedef struct {
    int                cyc;
    logic [NC*CW-1:0]  t;
    logic [NC*CWS-1:0] ts;
    logic [2:0]        w;
    logic [2:0]        ws;
  } exp_t;

  exp_t sbq[$];

  function automatic logic [NC*CW-1:0] pack_m();
    logic [NC*CW-1:0] r;
    r = '0;
    for (int i = 0; i < NC; i++) r[i*CW +: CW] = CW'(em[i]);
    return r;
  endfunction

  function automatic logic [NC*CWS-1:0] pack_s();
    logic [NC*CWS-1:0] r;
    r = '0;
    for (int i = 0; i < NC; i++) r[i*CWS +: CWS] = CWS'(es[i]);
    return r;
  endfunction

  function automatic logic [2:0] win_of(input bit sat);
    int b;
    b = 0;
    for (int i = 1; i < NC; i++) begin
      if (sat ? (es[i] > es[b]) : (em[i] > em[b])) b = i;
    end
    return 3'(b);
  endfunction

  function automatic int idx_of(input logic [NC-1:0] btn);
    int r;
    r = 0;
    for (int i = 0; i < NC; i++) if (btn[i]) r = i;
    return r;
  endfunction

  task automatic clear_model();
    for (int i = 0; i < NC; i++) begin
      em[i] = 0;
      es[i] = 0;
    end
  endtask

  // Called at the moment cast is raised; the ack is due L+2 edges later.
  task automatic push_vote(input int idx);
    exp_t e;
    if (em[idx] < (1 << CW) - 1)  em[idx] = em[idx] + 1;
    if (es[idx] < (1 << CWS) - 1) es[idx] = es[idx] + 1;
    e.cyc = cyc + L + 2;
    e.t   = pack_m();
    e.ts  = pack_s();
    e.w   = win_of(1'b0);
    e.ws  = win_of(1'b1);
    sbq.push_back(e);
  endtask

  always @(posedge CLK) begin
    exp_t e;
    #1;
    if (vote_ack || vote_ack_sat) begin
      chk("ack_expected", 64'(sbq.size() != 0), 64'd1);
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        chk("ack_cycle", 64'(cyc), 64'(e.cyc));
        chk("ack_main", vote_ack, 1'b1);
        chk("ack_sat", vote_ack_sat, 1'b1);
        chk("ack_tally", tally, e.t);
        chk("ack_tally_sat", tally_sat, e.ts);
        chk("ack_winner", winner, e.w);
        chk("ack_winner_sat", winner_sat, e.ws);
      end
    end
  end

  // Raise cast from SELECT, check the evaluation edge, then let the filtered cast settle low.
  task automatic cast_and_check(input logic [NC-1:0] btn, input bit valid, input bit close);
    if (valid) push_vote(idx_of(btn));
    cast = 1'b1;
    repeat (L) step();
    cast = 1'b0;
    close_poll = close;
    step();
    close_poll = 1'b0;
    chk("eval_err", err, !valid);
    chk("eval_err_sat", err_sat, !valid);
    chk("eval_no_ack", vote_ack, 1'b0);
    step();
    chk("err_one_cycle", err, 1'b0);
    repeat (L) step();
    chk("tally_after", tally, pack_m());
    chk("tally_sat_after", tally_sat, pack_s());
  endtask

  task automatic do_reset();
    RST = 1'b1;
    step();
    RST = 1'b0;
    clear_model();
  endtask

  typedef struct {
    logic [NC-1:0] btn;
    bit            valid;
  } vec_t;

  vec_t vecs[13];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bit in_select;

    vecs[0]  = '{4'b0110, 1'b0};
    vecs[1]  = '{4'b0000, 1'b0};
    vecs[2]  = '{4'b0010, 1'b1};
    vecs[3]  = '{4'b1000, 1'b1};
    vecs[4]  = '{4'b1000, 1'b1};
    vecs[5]  = '{4'b0001, 1'b1};
    vecs[6]  = '{4'b0100, 1'b1};
    vecs[7]  = '{4'b1000, 1'b1};
    vecs[8]  = '{4'b1000, 1'b1};
    vecs[9]  = '{4'b1111, 1'b0};
    vecs[10] = '{4'b0001, 1'b1};
    vecs[11] = '{4'b0001, 1'b1};
    vecs[12] = '{4'b0001, 1'b1};

    RST = 1'b1; voter_en = 1'b0; cand_btn = '0; cast = 1'b0; close_poll = 1'b0;
    clear_model();
    step();
    step();
    chk("rst_busy", busy, 1'b0);
    chk("rst_ack", vote_ack, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_closed", poll_closed, 1'b0);
    chk("rst_winner", winner, 3'd0);
    chk("rst_tally", tally, '0);
    chk("rst_tally_sat", tally_sat, '0);
    RST = 1'b0;
    step();

    in_select = 1'b0;
    for (int k = 0; k < 13; k++) begin
      cand_btn = vecs[k].btn;
      if (!in_select) begin
        voter_en = 1'b1;
        step();
        chk("vec_busy_select", busy, 1'b1);
        in_select = 1'b1;
      end else begin
        step();
      end
      cast_and_check(vecs[k].btn, vecs[k].valid, 1'b0);
      if (vecs[k].valid) begin
        chk("vec_busy_wait_rel", busy, 1'b1);
        voter_en = 1'b0;
        step();
        chk("vec_busy_idle", busy, 1'b0);
        in_select = 1'b0;
      end else begin
        chk("vec_stay_select", busy, 1'b1);
      end
    end
    chk("final_winner", winner, 3'd0);
    chk("final_winner_sat", winner_sat, 3'd0);

    // Second cast under the same authorisation is ignored.
    cand_btn = 4'b0100;
    voter_en = 1'b1;
    step();
    cast_and_check(4'b0100, 1'b1, 1'b0);
    cast = 1'b1;
    repeat (L) step();
    cast = 1'b0;
    repeat (L + 3) step();
    chk("dup_busy", busy, 1'b1);
    chk("dup_err", err, 1'b0);
    chk("dup_tally", tally, pack_m());
    voter_en = 1'b0;
    step();
    chk("dup_idle", busy, 1'b0);

    // Reset while COMMIT is in flight.
    cand_btn = 4'b0010;
    voter_en = 1'b1;
    step();
    cast = 1'b1;
    repeat (L) step();
    cast = 1'b0;
    step();
    RST = 1'b1;
    step();
    RST = 1'b0;
    voter_en = 1'b0;
    clear_model();
    chk("rc_ack", vote_ack, 1'b0);
    chk("rc_tally", tally, '0);
    chk("rc_tally_sat", tally_sat, '0);
    chk("rc_busy", busy, 1'b0);
    chk("rc_winner", winner, 3'd0);
    repeat (L + 2) step();
    chk("rc_still_idle", busy, 1'b0);
    chk("rc_still_zero", tally, '0);

    // Close from SELECT without a cast discards the session.
    cand_btn = 4'b1000;
    voter_en = 1'b1;
    step();
    chk("cs_busy", busy, 1'b1);
    close_poll = 1'b1;
    step();
    close_poll = 1'b0;
    chk("cs_closed", poll_closed, 1'b1);
    chk("cs_busy_off", busy, 1'b0);
    chk("cs_tally", tally, '0);
    voter_en = 1'b0;
    do_reset();
    chk("cs_rst_open", poll_closed, 1'b0);

    // Close seen during COMMIT: vote counted, then CLOSED.
    cand_btn = 4'b0010;
    voter_en = 1'b1;
    step();
    push_vote(1);
    cast = 1'b1;
    repeat (L) step();
    cast = 1'b0;
    step();
    close_poll = 1'b1;
    step();
    close_poll = 1'b0;
    chk("cc_closed", poll_closed, 1'b1);
    chk("cc_busy", busy, 1'b0);
    chk("cc_tally", tally, pack_m());
    voter_en = 1'b0;
    repeat (L + 2) step();
    do_reset();

    // Valid cast with close in the same cycle, then the booth stays frozen.
    cand_btn = 4'b0001;
    voter_en = 1'b1;
    step();
    cast_and_check(4'b0001, 1'b1, 1'b1);
    chk("vc_closed", poll_closed, 1'b1);
    chk("vc_busy", busy, 1'b0);
    chk("vc_winner", winner, 3'd0);
    cand_btn = 4'b0010;
    cast = 1'b1;
    repeat (L) step();
    cast = 1'b0;
    repeat (L + 4) step();
    chk("vc_frozen", tally, pack_m());
    chk("vc_still_closed", poll_closed, 1'b1);
    chk("vc_no_busy", busy, 1'b0);
    voter_en = 1'b0;
    do_reset();

    // Close from IDLE takes priority over authorisation.
    voter_en = 1'b1;
    close_poll = 1'b1;
    step();
    close_poll = 1'b0;
    voter_en = 1'b0;
    chk("ic_closed", poll_closed, 1'b1);
    chk("ic_busy", busy, 1'b0);
    do_reset();

    repeat (4) step();
    chk("sb_drained", 64'(sbq.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
